mux2_arb: RTL and testbench

Round-robin arbiter with a registered output stage. It sits directly upstream of the `MUX2` data selector and drives its `sel` input. Two `width`-bit sources present valid/ready streams; the arbiter grants one per beat and steers it through an internal `MUX2` instance into a one-entry output register. The select it applies is exported for observation.

---
 rtl/mux2_pkg.sv | 19 +
 rtl/mux2_arb_mux2.sv | 13 +
 rtl/mux2_arb.sv | 109 ++++++++++
 tb/tb_mux2_arb.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mux2_pkg.sv
// mux2_pkg: shared definitions for the MUX2 data selector and the mux2_arb arbiter.
// Holds the arbiter FSM encodings and the select values that pick each source.
package mux2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Lock state owned by whichever source the select currently points at.
  function automatic arb_state_t lock_state(input logic s);
    return (s == SEL_B) ? LOCK_B : LOCK_A;
  endfunction

endpackage

// File: rtl/mux2_arb_mux2.sv
// MUX2: two-input data selector; sel=0 passes a_data, sel=1 passes b_data.
module MUX2 #(
  parameter int width = 8
) (
  input  logic             sel,
  input  logic [width-1:0] a_data,
  input  logic [width-1:0] b_data,
  output logic [width-1:0] y
);

  assign y = sel ? b_data : a_data;

endmodule

// File: rtl/mux2_arb.sv
// mux2_arb: round-robin arbiter over two valid/ready sources feeding a one-entry output register.
// Define MUX2_ARB_LOCK_EN to add a_last/b_last and hold the grant across multi-beat transfers.
module mux2_arb
  import mux2_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [width-1:0] a_data,
  output logic             a_ready,
`ifdef MUX2_ARB_LOCK_EN
  input  logic             a_last,
`endif
  input  logic             b_valid,
  input  logic [width-1:0] b_data,
  output logic             b_ready,
`ifdef MUX2_ARB_LOCK_EN
  input  logic             b_last,
`endif
  output logic             out_valid,
  output logic [width-1:0] out_data,
  input  logic             out_ready,
  output logic             sel
);

  arb_state_t       state;
  arb_state_t       state_next;
  logic             last_sel;
  logic             sel_q;
  logic             load;
  logic             accept;
  logic [width-1:0] mux_y;
`ifdef MUX2_ARB_LOCK_EN
  logic             beat_last;
`endif

  MUX2 #(
    .width(width)
  ) u_mux2 (
    .sel   (sel),
    .a_data(a_data),
    .b_data(b_data),
    .y     (mux_y)
  );

  // A lock pins the grant; otherwise contention goes to whoever did not win last.
  always_comb begin
    sel = sel_q;
    case (state)
      LOCK_A:  sel = SEL_A;
      LOCK_B:  sel = SEL_B;
      default: begin
        if (a_valid && b_valid) sel = ~last_sel;
        else if (a_valid)       sel = SEL_A;
        else if (b_valid)       sel = SEL_B;
      end
    endcase
  end

  assign load    = !out_valid || out_ready;
  assign a_ready = rst_n && load && a_valid && (sel == SEL_A);
  assign b_ready = rst_n && load && b_valid && (sel == SEL_B);
  assign accept  = a_ready || b_ready;

`ifdef MUX2_ARB_LOCK_EN
  assign beat_last = (sel == SEL_B) ? b_last : a_last;
`endif

  always_comb begin
    state_next = state;
`ifdef MUX2_ARB_LOCK_EN
    if (accept) begin
      state_next = beat_last ? IDLE : lock_state(sel);
    end
`else
    state_next = IDLE;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // last_sel starts at B so that A wins the first contention after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= SEL_A;
      last_sel  <= SEL_B;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      sel_q <= sel;
      if (accept) begin
        out_data  <= mux_y;
        out_valid <= 1'b1;
        last_sel  <= sel;
      end else if (load) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux2_arb.sv
// tb_mux2_arb: directed and randomized checks of mux2_arb against a behavioural model of the
// arbitration rules; lock expectations apply when MUX2_ARB_LOCK_EN is defined.
module tb_mux2_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic       a_ready;
  logic       a_last = 1'b1;
  logic       b_valid = 1'b0;
  logic [7:0] b_data = 8'h00;
  logic       b_ready;
  logic       b_last = 1'b1;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b1;
  logic       sel;

  int checks = 0;
  int failures = 0;

  // Model: who holds the output, who won last, who owns a lock (0 none, 1 A, 2 B)
  bit       m_ov = 1'b0;
  bit [7:0] m_od = 8'h00;
  bit       m_last = 1'b1;
  bit       m_prev = 1'b0;
  int       m_owner = 0;

  mux2_arb #(
    .width(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_data   (a_data),
    .a_ready  (a_ready),
`ifdef MUX2_ARB_LOCK_EN
    .a_last   (a_last),
`endif
    .b_valid  (b_valid),
    .b_data   (b_data),
    .b_ready  (b_ready),
`ifdef MUX2_ARB_LOCK_EN
    .b_last   (b_last),
`endif
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .sel      (sel)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic av, input logic [7:0] ad, input logic al,
                               input logic bv, input logic [7:0] bd, input logic bl, input logic ordy);
    @(negedge clk);
    rst_n     = rst;
    a_valid   = av;
    a_data    = ad;
    a_last    = al;
    b_valid   = bv;
    b_data    = bd;
    b_last    = bl;
    out_ready = ordy;
    #3;
  endtask

  // Compare process: every cycle, derive the grant from the rules and check all outputs.
  initial begin
    bit e_sel, e_load, e_ar, e_br, acc_last;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        m_ov = 1'b0; m_od = 8'h00; m_last = 1'b1; m_prev = 1'b0; m_owner = 0;
      end
      if (m_owner == 1)            e_sel = 1'b0;
      else if (m_owner == 2)       e_sel = 1'b1;
      else if (a_valid && b_valid) e_sel = !m_last;
      else if (a_valid)            e_sel = 1'b0;
      else if (b_valid)            e_sel = 1'b1;
      else                         e_sel = m_prev;
      e_load = !m_ov || out_ready;
      e_ar = rst_n && e_load && a_valid && !e_sel;
      e_br = rst_n && e_load && b_valid && e_sel;
      checkOutput("model_sel", sel, e_sel);
      checkOutput("model_a_ready", a_ready, e_ar);
      checkOutput("model_b_ready", b_ready, e_br);
      checkOutput("model_out_valid", out_valid, m_ov);
      checkOutput("model_out_data", out_data, m_od);
      if (rst_n) begin
        @(posedge clk);
        m_prev = e_sel;
        if (e_ar || e_br) begin
          m_od   = e_sel ? b_data : a_data;
          m_ov   = 1'b1;
          m_last = e_sel;
`ifdef MUX2_ARB_LOCK_EN
          acc_last = e_sel ? b_last : a_last;
`else
          acc_last = 1'b1;
`endif
          m_owner = acc_last ? 0 : (e_sel ? 2 : 1);
        end else if (e_load) begin
          m_ov = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset held with both sources valid
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
      checkOutput("reset_out_valid", out_valid, 1'b0);
      checkOutput("reset_out_data", out_data, 8'h00);
      checkOutput("reset_sel", sel, 1'b0);
      checkOutput("reset_a_ready", a_ready, 1'b0);
      checkOutput("reset_b_ready", b_ready, 1'b0);
    end

    // Contention after release: A, B, A, B
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
      checkOutput("contend_sel", sel, (i % 2 == 1));
      checkOutput("contend_a_ready", a_ready, (i % 2 == 0));
      checkOutput("contend_b_ready", b_ready, (i % 2 == 1));
      if (i == 1) checkOutput("first_beat_data", out_data, 8'hFF);
      if (i == 2) checkOutput("second_beat_data", out_data, 8'h00);
    end

    // Backpressure with 5A held
    applyStimulus(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("bp_load_a_ready", a_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("bp_out_data", out_data, 8'h5A);
      checkOutput("bp_out_valid", out_valid, 1'b1);
      checkOutput("bp_a_ready", a_ready, 1'b0);
      checkOutput("bp_b_ready", b_ready, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("bp_release_a_ready", a_ready, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("bp_next_data", out_data, 8'h11);
    checkOutput("bp_next_valid", out_valid, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("drain_out_valid", out_valid, 1'b0);

    // Only B valid, last=0
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h30 + i), 1'b0, 1'b1);
      checkOutput("single_b_ready", b_ready, 1'b1);
      checkOutput("single_a_ready", a_ready, 1'b0);
      checkOutput("single_sel", sel, 1'b1);
    end

    // Reset in the middle of a B transfer
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b1);
      checkOutput("midreset_out_valid", out_valid, 1'b0);
      checkOutput("midreset_b_ready", b_ready, 1'b0);
    end

    // A sends last = 0,0,1 while B waits, then B
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'hA0 + i), (i >= 2), 1'b1, 8'hB0, 1'b1, 1'b1);
      if (i == 0) checkOutput("after_reset_a_wins", a_ready, 1'b1);
`ifdef MUX2_ARB_LOCK_EN
      checkOutput("lock_b_ready", b_ready, (i == 3));
`else
      if (i == 1) checkOutput("nolock_b_ready", b_ready, 1'b1);
`endif
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) != 0), 1'($urandom), 8'($urandom), 1'($urandom),
                    1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
    end

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
